// File: rtl/seq_mult_pkg.sv
// Shared state encoding for the shift-add multiplier controller.
package seq_mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_step_cnt.sv
// Iteration counter for the multiplier controller: clear has priority over
// enable, and the count saturates at WIDTH instead of wrapping.
module mult_step_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Step count register with saturation at WIDTH
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (en && (cnt != CNT_W'(WIDTH))) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add sequential multiplier datapath.
// Optional early exit on an all-zero multiplier: define SEQ_MULT_EARLY_EXIT_EN.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic             abort,
    input  logic             mplr_lsb,
    input  logic             mplr_zero,
    output logic             ld_en,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step
);

    state_t state;
    logic   calc;
    logic   suppress;
    logic   at_last;
    logic   cnt_clr;
    logic   cnt_en;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Nothing left to add once the multiplier is zero; datapath pre-aligns the product.
    assign suppress = mplr_zero;
`else
    logic unused_zero;
    assign unused_zero = mplr_zero;
    assign suppress    = 1'b0;
`endif

    assign at_last  = (step == CNT_W'(WIDTH - 1));
    assign shift_en = calc & ~suppress;
    assign add_en   = calc & ~suppress & mplr_lsb;
    assign cnt_en   = shift_en;
    // Outside CALC the count is either being held at WIDTH for DONE or is zero.
    assign cnt_clr  = (state != CALC) | abort;

    mult_step_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk  (clk),
        .aclr (aclr),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (step)
    );

    // Sequencing FSM; strobes are registered decodes of the next state
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
            ld_en <= 1'b0;
            calc  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ld_en <= 1'b0;
            calc  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= LOAD;
                        ld_en <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state <= CALC;
                        calc  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (suppress || at_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        state <= CALC;
                        calc  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: operation-age reference model plus directed pins.
module tb_seq_mult_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          aclr;
    logic          start;
    logic          abort;
    logic          mplr_lsb;
    logic          mplr_zero;
    logic          ld_en;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] step;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    // age: cycles since the accepting start edge (0 = idle); mstep: iterations done
    int age = 0;
    int mstep = 0;
    int done_q[$];
    int add_cnt = 0;
    int shift_cnt = 0;
    int last_done_step = -1;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .start     (start),
        .abort     (abort),
        .mplr_lsb  (mplr_lsb),
        .mplr_zero (mplr_zero),
        .ld_en     (ld_en),
        .add_en    (add_en),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done),
        .step      (step)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic int last_done();
        return (done_q.size() > 0) ? done_q[$] : -1;
    endfunction

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic cycle(input logic s, input logic a, input logic l, input logic z);
        logic sup;
        logic e_shift;
        start     = s;
        abort     = a;
        mplr_lsb  = l;
        mplr_zero = z;
        #1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        sup = z;
`else
        sup = 1'b0;
`endif
        e_shift = (age >= 2) && (age <= W + 1) && !sup;
        chk("ld_en",    int'(ld_en),    int'(age == 1));
        chk("busy",     int'(busy),     int'(age != 0));
        chk("shift_en", int'(shift_en), int'(e_shift));
        chk("add_en",   int'(add_en),   int'(e_shift && l));
        chk("done",     int'(done),     int'(age == W + 2));
        chk("step",     int'(step),     mstep);
        if (add_en)   add_cnt++;
        if (shift_en) shift_cnt++;
        if (done) begin
            done_q.push_back(cyc);
            last_done_step = int'(step);
        end
        @(posedge clk);
        cyc++;
        if (age == 0) begin
            age   = (s && !a) ? 1 : 0;
            mstep = 0;
        end else if (a || (age == W + 2)) begin
            age   = 0;
            mstep = 0;
        end else if (age >= 2) begin
            if (sup) begin
                age = W + 2;
            end else begin
                mstep++;
                age++;
            end
        end else begin
            age++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
    endtask

    initial begin
        int t0, n0, a0, s0, k, d1, d2;
        logic [7:0] pat;
        logic s, a, z;

        aclr = 1'b1; start = 1'b0; abort = 1'b0; mplr_lsb = 1'b0; mplr_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_en", int'(ld_en), 0);
        chk("rst_add_en", int'(add_en), 0);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step", int'(step), 0);
        aclr = 1'b0;
        idle(20);
        chk("idle_no_done", done_q.size(), 0);

        // Single operation with multiplier LSB pattern 1,0,1,1,0,0,0,0
        pat = 8'b0000_1101;
        t0 = cyc; n0 = done_q.size(); a0 = add_cnt; s0 = shift_cnt;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b0, 1'b0, pat[i], 1'b0);
        idle(2);
        chk("op_done_count", done_q.size() - n0, 1);
        chk("op_done_cycle", last_done() - t0, W + 2);
        chk("op_done_step", last_done_step, W);
        chk("op_add_count", add_cnt - a0, 3);
        chk("op_shift_count", shift_cnt - s0, W);

        // Abort at cycle 4 (third CALC cycle), then a clean operation
        t0 = cyc; n0 = done_q.size();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_step", int'(step), 0);
        idle(12);
        chk("abort_no_done", done_q.size() - n0, 0);
        t0 = cyc;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        chk("after_abort_done_cycle", last_done() - t0, W + 2);

        // start held high for 30 cycles
        t0 = cyc; n0 = done_q.size();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
        idle(15);
        k = 0; d1 = -1; d2 = -1;
        for (int i = n0; i < done_q.size(); i++) begin
            if (done_q[i] < t0 + 30) begin
                if (k == 0) d1 = done_q[i];
                else if (k == 1) d2 = done_q[i];
                k++;
            end
        end
        chk("held_done_count", k, 2);
        chk("held_done1", d1 - t0, W + 2);
        chk("held_done2", d2 - t0, 2 * W + 5);

        // start and abort together in IDLE
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_ld_en", int'(ld_en), 0);
        idle(2);

        // Asynchronous clear in the middle of CALC
        n0 = done_q.size();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        #2;
        aclr = 1'b1;
        #1;
        age = 0; mstep = 0;
        chk("aclr_busy", int'(busy), 0);
        chk("aclr_shift_en", int'(shift_en), 0);
        chk("aclr_step", int'(step), 0);
        @(posedge clk);
        cyc++;
        #1;
        aclr = 1'b0;
        idle(14);
        chk("aclr_no_done", done_q.size() - n0, 0);

        // mplr_zero raised from the CALC cycle whose step is 3
        t0 = cyc; n0 = done_q.size();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("zero_done_count", done_q.size() - n0, 1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        chk("zero_done_cycle", last_done() - t0, 6);
        chk("zero_done_step", last_done_step, 3);
`else
        chk("zero_done_cycle", last_done() - t0, W + 2);
        chk("zero_done_step", last_done_step, W);
`endif

        // Randomised traffic against the model
        n0 = done_q.size();
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(3) == 0);
            a = ($urandom_range(24) == 0);
`ifdef SEQ_MULT_EARLY_EXIT_EN
            z = ($urandom_range(11) == 0);
`else
            z = 1'($urandom_range(1));
`endif
            cycle(s, a, 1'($urandom_range(1)), z);
        end
        idle(W + 4);
        chk("random_some_done", int'(done_q.size() > n0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
